// File: rtl/fetch_ctrl_pkg.sv
// Shared fetch-stage definitions: FSM states, buffer entry layout, NOP encoding
// and the word-alignment helper used wherever an address enters the fetch path.
package fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Instruction buffer between memory responses and decode: synchronous FIFO of
// {pc, instr} entries with a flush that empties it in one cycle.
module fetch_buffer
    import fetch_ctrl_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  fetch_entry_t           push_data,
    input  logic                   pop,
    output fetch_entry_t           head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty
);
    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0] ZERO_CNT = (AW + 1)'(0);

    fetch_entry_t  mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic          do_push_s;
    logic          do_pop_s;

    // Qualify push/pop against current occupancy
    always_comb begin
        do_push_s = push && (count_r != FULL_CNT);
        do_pop_s  = pop && (count_r != ZERO_CNT);
    end

    // Pointers and occupancy; flush wins over any same-cycle push or pop
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            count_r  <= ZERO_CNT;
        end else if (flush) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            count_r  <= ZERO_CNT;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + (AW + 1)'(1);
                2'b01:   count_r <= count_r - (AW + 1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; unused slots hold a NOP
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {32'h0000_0000, NOP};
            end
        end else if (do_push_s && !flush) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign count = count_r;
    assign empty = (count_r == ZERO_CNT);

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: single-outstanding memory requester with
// credit-based flow control, redirect flush and stale-response discard.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc_plus4
);
    localparam int          CW      = $clog2(BUF_DEPTH) + 1;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(BUF_DEPTH);

    fetch_state_e  state_r, state_s;
    logic [31:0]   pc_r, pc_s;
    logic [31:0]   rec_addr_r, rec_addr_s;
    logic          outstanding_r, outstanding_s;
    logic          discard_r, discard_s;

    logic [CW-1:0] count_s;
    logic          empty_s;
    fetch_entry_t  head_s;
    fetch_entry_t  push_data_s;
    logic [CW:0]   occupancy_s;
    logic [CW:0]   count_after_s;
    logic          credit_s, req_valid_s, accept_s, rsp_take_s;
    logic          push_s, pop_s, out_valid_s;

    // Credit, handshakes and buffer traffic for this cycle
    always_comb begin
        occupancy_s   = {1'b0, count_s} + {{CW{1'b0}}, outstanding_r};
        credit_s      = (occupancy_s < DEPTH_W);
        req_valid_s   = (state_r == ST_REQ) && credit_s && !outstanding_r;
        accept_s      = req_valid_s && imem_req_ready;
        rsp_take_s    = imem_rsp_valid && outstanding_r;
        out_valid_s   = !empty_s && !redirect_valid;
        pop_s         = out_valid_s && out_ready;
        push_s        = rsp_take_s && !discard_r && !redirect_valid;
        push_data_s   = {rec_addr_r, imem_rsp_data};
        count_after_s = {1'b0, count_s} + {{CW{1'b0}}, push_s} - {{CW{1'b0}}, pop_s};
    end

    // Next-state logic; a redirect overrides every other event
    always_comb begin
        state_s       = state_r;
        pc_s          = pc_r;
        rec_addr_s    = rec_addr_r;
        outstanding_s = outstanding_r;
        discard_s     = discard_r;
        if (redirect_valid) begin
            state_s       = ST_REQ;
            pc_s          = word_align(redirect_pc);
            outstanding_s = accept_s || (outstanding_r && !imem_rsp_valid);
            discard_s     = outstanding_s;
            if (accept_s) begin
                rec_addr_s = pc_r;
            end else begin
                rec_addr_s = rec_addr_r;
            end
        end else begin
            if (accept_s) begin
                pc_s          = pc_r + 32'd4;
                rec_addr_s    = pc_r;
                outstanding_s = 1'b1;
            end else if (rsp_take_s) begin
                outstanding_s = 1'b0;
                discard_s     = 1'b0;
            end else begin
                outstanding_s = outstanding_r;
            end
            case (state_r)
                ST_IDLE: begin
                    if (credit_s) state_s = ST_REQ;
                    else          state_s = ST_IDLE;
                end
                ST_REQ: begin
                    if (accept_s) state_s = ST_WAIT;
                    else          state_s = ST_REQ;
                end
                ST_WAIT: begin
                    if (rsp_take_s) state_s = (count_after_s < DEPTH_W) ? ST_REQ : ST_IDLE;
                    else            state_s = ST_WAIT;
                end
                default: state_s = ST_IDLE;
            endcase
        end
    end

    // Control state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r       <= ST_IDLE;
            pc_r          <= word_align(RESET_PC);
            rec_addr_r    <= 32'h0000_0000;
            outstanding_r <= 1'b0;
            discard_r     <= 1'b0;
        end else begin
            state_r       <= state_s;
            pc_r          <= pc_s;
            rec_addr_r    <= rec_addr_s;
            outstanding_r <= outstanding_s;
            discard_r     <= discard_s;
        end
    end

    fetch_buffer #(
        .DEPTH(BUF_DEPTH)
    ) u_buffer (
        .clk      (clk),
        .rst      (rst),
        .flush    (redirect_valid),
        .push     (push_s),
        .push_data(push_data_s),
        .pop      (pop_s),
        .head     (head_s),
        .count    (count_s),
        .empty    (empty_s)
    );

    assign imem_req_valid = req_valid_s;
    assign imem_req_addr  = pc_r;
    assign out_valid      = out_valid_s;
    assign out_instr      = empty_s ? 32'h0000_0000 : head_s.instr;
    assign out_pc         = empty_s ? 32'h0000_0000 : head_s.pc;
    assign out_pc_plus4   = empty_s ? 32'h0000_0000 : head_s.pc + 32'd4;

endmodule
